// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo_gen FIFO family.
// Holds the read-mode encoding and the occupancy-count width helper.
package sync_fifo_pkg;

    typedef enum logic {
        STD_READ  = 1'b0,
        FWFT_READ = 1'b1
    } readMode_e;

    // Count needs one extra bit so a completely full FIFO is representable.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_gen: synchronous write, asynchronous read.
// Contents are never cleared; the pointers alone decide which words are live.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds and optional FWFT read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with errClr.
module sync_fifo_gen
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fifoWrEn,
    input  logic [FIFO_WIDTH-1:0]                fifoWrData,
    input  logic                                 fifoRdEn,
    output logic [FIFO_WIDTH-1:0]                fifoRdData,
    output logic                                 fifoRdValid,
    output logic                                 fifoFull,
    output logic                                 fifoEmpty,
    output logic                                 fifoAlmostFull,
    output logic                                 fifoAlmostEmpty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                                 errClr,
    output logic                                 fifoOverflow,
    output logic                                 fifoUnderflow,
`endif
    output logic [countWidth(FIFO_DEPTH)-1:0]    fifoDataCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = countWidth(FIFO_DEPTH);
    localparam readMode_e MODE = (FWFT != 0) ? FWFT_READ : STD_READ;

    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] ramRdData;
    logic                  wrAcc;
    logic                  rdAcc;

    assign wrAcc = fifoWrEn && !fifoFull;
    assign rdAcc = fifoRdEn && !fifoEmpty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (wrAcc && !rdAcc) begin
            count_d = count_q + CW'(1);
        end else if (rdAcc && !wrAcc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Flags come straight from the registered count, so they never glitch.
    assign fifoFull        = (count_q == CW'(FIFO_DEPTH));
    assign fifoEmpty       = (count_q == '0);
    assign fifoAlmostFull  = (count_q >= CW'(AF_LEVEL));
    assign fifoAlmostEmpty = (count_q <= CW'(AE_LEVEL));
    assign fifoDataCount   = count_q;

    sync_fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) uRam (
        .clk    (clk),
        .wrEn   (wrAcc),
        .wrAddr (wrPtr_q),
        .wrData (fifoWrData),
        .rdAddr (rdPtr_q),
        .rdData (ramRdData)
    );

    generate
        if (MODE == STD_READ) begin : gStdRead
            logic [FIFO_WIDTH-1:0] rdData_q;
            logic                  rdValid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdData_q  <= '0;
                    rdValid_q <= 1'b0;
                end else begin
                    rdValid_q <= rdAcc;
                    if (rdAcc) begin
                        rdData_q <= ramRdData;
                    end
                end
            end

            assign fifoRdData  = rdData_q;
            assign fifoRdValid = rdValid_q;
        end else begin : gFwftRead
            assign fifoRdData  = ramRdData;
            assign fifoRdValid = !fifoEmpty;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event wins over a simultaneous clear so no event is lost.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (errClr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (fifoWrEn && fifoFull) begin
            overflow_d = 1'b1;
        end
        if (fifoRdEn && fifoEmpty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifoOverflow  = overflow_q;
    assign fifoUnderflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench for sync_fifo_gen: standard and FWFT instances share stimulus,
// checked against vector tables, hand sequences and a queue-based reference model.
module tb_sync_fifo_gen;

    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       wrEn;
    logic [7:0] wrData;
    logic       rdEn;
    logic       errClr;

    logic [7:0] sRdData, fRdData;
    logic       sRdValid, fRdValid;
    logic       sFull, fFull, sEmpty, fEmpty;
    logic       sAF, fAF, sAE, fAE;
    logic [4:0] sCount, fCount;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       sOvf, sUnf, fOvf, fUnf;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] expStdData;
    logic       expStdValid;
    logic       expOvf, expUnf;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        int         expCount;
        logic       expFull;
        logic       expAF;
        logic       expValid;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sync_fifo_gen #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0)) uStd (
        .clk             (clk),
        .reset           (reset),
        .fifoWrEn        (wrEn),
        .fifoWrData      (wrData),
        .fifoRdEn        (rdEn),
        .fifoRdData      (sRdData),
        .fifoRdValid     (sRdValid),
        .fifoFull        (sFull),
        .fifoEmpty       (sEmpty),
        .fifoAlmostFull  (sAF),
        .fifoAlmostEmpty (sAE),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .errClr          (errClr),
        .fifoOverflow    (sOvf),
        .fifoUnderflow   (sUnf),
`endif
        .fifoDataCount   (sCount)
    );

    sync_fifo_gen #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1)) uFwft (
        .clk             (clk),
        .reset           (reset),
        .fifoWrEn        (wrEn),
        .fifoWrData      (wrData),
        .fifoRdEn        (rdEn),
        .fifoRdData      (fRdData),
        .fifoRdValid     (fRdValid),
        .fifoFull        (fFull),
        .fifoEmpty       (fEmpty),
        .fifoAlmostFull  (fAF),
        .fifoAlmostEmpty (fAE),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .errClr          (errClr),
        .fifoOverflow    (fOvf),
        .fifoUnderflow   (fUnf),
`endif
        .fifoDataCount   (fCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares both instances against the queue model's view of the FIFO.
    task automatic checkOutput();
        int n;
        n = q.size();
        check("count",     32'(sCount),  32'(n));
        check("empty",     32'(sEmpty),  32'(n == 0));
        check("full",      32'(sFull),   32'(n == DEPTH));
        check("almFull",   32'(sAF),     32'(n >= AF));
        check("almEmpty",  32'(sAE),     32'(n <= AE));
        check("stdValid",  32'(sRdValid), 32'(expStdValid));
        check("stdData",   32'(sRdData), 32'(expStdData));
        check("fwftCount", 32'(fCount),  32'(n));
        check("fwftValid", 32'(fRdValid), 32'(n != 0));
        if (n != 0) begin
            check("fwftData", 32'(fRdData), 32'(q[0]));
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow",  32'(sOvf), 32'(expOvf));
        check("underflow", 32'(sUnf), 32'(expUnf));
        check("fwftOvf",   32'(fOvf), 32'(expOvf));
        check("fwftUnf",   32'(fUnf), 32'(expUnf));
`endif
    endtask

    // Drives one clock of stimulus, advances the model, then checks.
    task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] d,
                                 input logic rd, input logic clr);
        logic wasFull, wasEmpty;
        reset  = rst;
        wrEn   = wr;
        wrData = d;
        rdEn   = rd;
        errClr = clr;
        @(posedge clk);
        #1;
        wasFull  = (q.size() == DEPTH);
        wasEmpty = (q.size() == 0);
        if (rst) begin
            q.delete();
            expStdData  = 8'h00;
            expStdValid = 1'b0;
            expOvf      = 1'b0;
            expUnf      = 1'b0;
        end else begin
            if (wr && wasFull) expOvf = 1'b1;
            else if (clr)      expOvf = 1'b0;
            if (rd && wasEmpty) expUnf = 1'b1;
            else if (clr)       expUnf = 1'b0;
            expStdValid = 1'b0;
            if (rd && !wasEmpty) begin
                expStdData  = q.pop_front();
                expStdValid = 1'b1;
            end
            if (wr && !wasFull) q.push_back(d);
        end
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back('{1'b1, 8'(i + 1), 1'b0, i + 1, i == DEPTH - 1, (i + 1) >= AF, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 8'hAA, 1'b0, DEPTH, 1'b1, 1'b1, 1'b0, 8'h00});
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back('{1'b0, 8'h00, 1'b1, DEPTH - 1 - i, 1'b0, (DEPTH - 1 - i) >= AF, 1'b1, 8'(i + 1)});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h10});
        vecs.push_back('{1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h10});

        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rstCount", 32'(sCount),  32'd0);
        check("rstEmpty", 32'(sEmpty),  32'd1);
        check("rstFull",  32'(sFull),   32'd0);
        check("rstAE",    32'(sAE),     32'd1);
        check("rstAF",    32'(sAF),     32'd0);
        check("rstValid", 32'(sRdValid), 32'd0);
        check("rstData",  32'(sRdData), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].wr, vecs[i].data, vecs[i].rd, 1'b0);
            check("tCount", 32'(sCount),   32'(vecs[i].expCount));
            check("tFull",  32'(sFull),    32'(vecs[i].expFull));
            check("tAF",    32'(sAF),      32'(vecs[i].expAF));
            check("tValid", 32'(sRdValid), 32'(vecs[i].expValid));
            check("tData",  32'(sRdData),  32'(vecs[i].expData));
        end

        while (q.size() < 8) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
            check("holdCount", 32'(sCount), 32'd8);
        end

        while (q.size() < DEPTH) applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 200)), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        check("fullBothCount", 32'(sCount), 32'd15);
        while (q.size() > 0) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwftFallValid", 32'(fRdValid), 32'd1);
        check("fwftFallData",  32'(fRdData),  32'h5A);
        check("fwftStdValid",  32'(sRdValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("fwftPopValid",  32'(fRdValid), 32'd0);
        check("fwftPopEmpty",  32'(fEmpty),   32'd1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        check("midRstCount", 32'(sCount),   32'd0);
        check("midRstEmpty", 32'(sEmpty),   32'd1);
        check("midRstValid", 32'(sRdValid), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("unfSet", 32'(sUnf), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("unfClr", 32'(sUnf), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            int wBias;
            wBias = ((i / 100) % 2 == 0) ? 75 : 25;
            applyStimulus($urandom_range(0, 99) < 1,
                          $urandom_range(0, 99) < wBias,
                          8'($urandom),
                          $urandom_range(0, 99) < (100 - wBias),
                          $urandom_range(0, 99) < 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_gen.md
Name: sync_fifo_gen

Overview:
Next-generation parametrised synchronous FIFO for single-clock datapaths.
- Replaces the fixed-latency FIFO. Writes commit on the accepting edge, with no input pipeline.
- Adds almost-full/almost-empty thresholds, a read-valid qualifier and a first-word-fall-through (FWFT) mode.
- Sits between producer and consumer blocks as elastic buffering and rate decoupling.

Parameters:
FIFO_WIDTH, 8, data word width in bits (>=1).
FIFO_DEPTH, 16, number of entries; power of two, >=2.
AF_LEVEL, FIFO_DEPTH-2, fifoAlmostFull asserted when count >= AF_LEVEL (1..FIFO_DEPTH).
AE_LEVEL, 2, fifoAlmostEmpty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-1).
FWFT, 0, 0 = standard registered-read mode; 1 = first-word-fall-through mode.

Ports:
clk  in  1  single clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
fifoWrEn  in  1  write request.
fifoWrData  in  FIFO_WIDTH  write data, sampled with fifoWrEn.
fifoRdEn  in  1  read request (standard) / pop (FWFT).
fifoRdData  out  FIFO_WIDTH  read data.
fifoRdValid  out  1  fifoRdData is valid.
fifoFull  out  1  count == FIFO_DEPTH.
fifoEmpty  out  1  count == 0.
fifoAlmostFull  out  1  count >= AF_LEVEL.
fifoAlmostEmpty  out  1  count <= AE_LEVEL.
fifoDataCount  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high (port reset), sampled on the clk rising edge.
- Accept rules:
  - Write accepted (wrAcc) = fifoWrEn && !fifoFull.
  - Read accepted (rdAcc) = fifoRdEn && !fifoEmpty.
  - Both use flag values before the edge. Refused requests are silently dropped; no state changes.
- Memory and pointers:
  - On wrAcc, mem[wrPtr] <= fifoWrData and wrPtr++ on the same edge.
  - On rdAcc, rdPtr++.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count:
  - +1 on wrAcc only; -1 on rdAcc only; unchanged when both or neither.
  - Width $clog2(FIFO_DEPTH)+1, so it never overflows.
- Flags: all decoded from the registered count, so they are glitch-free and update on the edge after the causing transaction.
- Simultaneous events:
  - Full with both requests: only the read is accepted; count drops to DEPTH-1.
  - Empty with both requests: only the write is accepted; count becomes 1.
  - Otherwise both are accepted and count holds.
- Standard mode (FWFT=0):
  - On rdAcc, fifoRdData <= mem[rdPtr] (1-cycle latency) and fifoRdValid <= 1 for exactly one cycle; otherwise fifoRdValid <= 0.
  - fifoRdData holds its last value when no read occurs.
- FWFT mode (FWFT=1):
  - fifoRdData = mem[rdPtr] combinationally; fifoRdValid = !fifoEmpty.
  - A word written into an empty FIFO is visible the cycle after its write edge.
  - fifoRdEn pops the head word; the next word is visible after the edge.
- Reset values:
  - Pointers 0, count 0.
  - fifoEmpty 1, fifoFull 0.
  - fifoAlmostEmpty 1, fifoAlmostFull 0.
  - fifoRdValid 0, fifoRdData 0 (standard-mode register).
  - Memory contents are not cleared.
- Reset mid-operation: all stored entries are discarded logically. Requests in the reset cycle are ignored.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds input errClr (1 bit) and outputs fifoOverflow and fifoUnderflow (1 bit each, sticky).
  - fifoOverflow sets the edge after fifoWrEn && fifoFull.
  - fifoUnderflow sets the edge after fifoRdEn && fifoEmpty.
  - Both clear on reset or errClr; a set event in the same cycle as errClr has priority.
- Undefined: these ports and their logic are absent; refused requests leave no trace.

Decomposition:
- Package sync_fifo_pkg holds the shared constants and typedefs:
  - the count-width localparam function (clog2+1);
  - an enum for the mode values (STD_READ=0, FWFT_READ=1).
- Sub-module sync_fifo_ram: simple dual-port RAM with a synchronous write port (wrEn, wrAddr, wrData) and an asynchronous read port (rdAddr, rdData).
  - The top level adds the output register for standard mode.

Test Plan:
- DEPTH=16, FWFT=0, write 0x01..0x10 back-to-back:
  - fifoFull=1 after the 16th edge, with fifoAlmostFull from count 14.
  - A 17th write of 0xAA is dropped; count stays 16.
- Full FIFO, 16 reads, FWFT=0:
  - fifoRdData = 0x01..0x10, each 1 cycle after rdAcc with fifoRdValid pulsing.
  - fifoEmpty=1 after the last read; a further read gives fifoRdValid=0.
- Count 8, fifoWrEn and fifoRdEn held 20 cycles: count stays 8, data order is preserved, and pointers wrap past 15 to 0.
- Empty with both requests high: count becomes 1 and fifoRdValid stays 0. Full with both high: count becomes 15 and the write data is not stored.
- FWFT=1, write 0x5A into empty:
  - The next cycle fifoRdValid=1 and fifoRdData=0x5A, before any fifoRdEn.
  - A pop returns to empty with fifoRdValid=0.
- Count 5, assert reset 1 cycle: count 0, fifoEmpty=1, fifoRdValid=0. Then with the macro defined, a read while empty sets fifoUnderflow, and errClr clears it.
